// File: rtl/demux_frame_assembler.sv
// Slot-addressed frame assembler: tagged words fill an N*M frame, handed off via valid/ready.
// Optional DEMUX_FRAME_AUTO_INC_EN adds wr_auto and an auto-incrementing slot pointer.
module demux_frame_assembler #(
    parameter int N = 12,
    parameter int M = 4,
    parameter int S = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [M-1:0]   wr_data,
    input  logic [S-1:0]   wr_sel,
`ifdef DEMUX_FRAME_AUTO_INC_EN
    input  logic           wr_auto,
`endif
    output logic [N*M-1:0] y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [N-1:0]   fill_mask,
    output logic           err_range,
    output logic           err_overwrite,
    input  logic           err_clr
);

    typedef enum logic {FILL, FULL} state_e;

    state_e         state_q, state_d;
    logic [N*M-1:0] y_q, y_d;
    logic [N-1:0]   mask_q, mask_d;
    logic           err_range_q, err_range_d;
    logic           err_ovw_q, err_ovw_d;
    logic           accept, handoff, in_range, hit_filled;
    logic [S-1:0]   slot;

`ifdef DEMUX_FRAME_AUTO_INC_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] ptr_q, ptr_d, ptr_eff;
`endif

    assign y_valid  = (state_q == FULL);
    assign wr_ready = !y_valid || y_ready;
    assign accept   = wr_valid && wr_ready;
    assign handoff  = y_valid && y_ready;

    always_comb begin
`ifdef DEMUX_FRAME_AUTO_INC_EN
        // A handoff restarts the pointer, even for a write in the same cycle
        ptr_eff = handoff ? '0 : ptr_q;
        ptr_d   = ptr_eff;
        slot    = wr_sel;
        if (wr_auto) begin
            slot = S'(ptr_eff);
            if (accept)
                ptr_d = (ptr_eff == PW'(N - 1)) ? '0 : ptr_eff + PW'(1);
        end
`else
        slot = wr_sel;
`endif
        in_range   = ({1'b0, slot} < (S + 1)'(N));
        y_d        = handoff ? '0 : y_q;
        mask_d     = handoff ? '0 : mask_q;
        hit_filled = 1'b0;
        if (accept && in_range) begin
            for (int k = 0; k < N; k++) begin
                if (slot == S'(k)) begin
                    hit_filled        = mask_d[k];
                    y_d[k*M +: M]     = wr_data;
                    mask_d[k]         = 1'b1;
                end
            end
        end
        state_d     = (&mask_d) ? FULL : FILL;
        err_range_d = err_clr ? 1'b0 : (err_range_q || (accept && !in_range));
        err_ovw_d   = err_clr ? 1'b0 : (err_ovw_q || hit_filled);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            y_q         <= '0;
            mask_q      <= '0;
            err_range_q <= 1'b0;
            err_ovw_q   <= 1'b0;
`ifdef DEMUX_FRAME_AUTO_INC_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            mask_q      <= mask_d;
            err_range_q <= err_range_d;
            err_ovw_q   <= err_ovw_d;
`ifdef DEMUX_FRAME_AUTO_INC_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign y             = y_q;
    assign fill_mask     = mask_q;
    assign err_range     = err_range_q;
    assign err_overwrite = err_ovw_q;

endmodule

// File: tb/tb_demux_frame_assembler.sv
// Directed self-checking bench for demux_frame_assembler (default 12x4 configuration).
module tb_demux_frame_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_data;
    logic [3:0]  wr_sel;
    logic [47:0] y;
    logic        y_valid;
    logic        y_ready;
    logic [11:0] fill_mask;
    logic        err_range;
    logic        err_overwrite;
    logic        err_clr;
`ifdef DEMUX_FRAME_AUTO_INC_EN
    logic        wr_auto = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_frame_assembler #(.N(12), .M(4), .S(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_sel        (wr_sel),
`ifdef DEMUX_FRAME_AUTO_INC_EN
        .wr_auto       (wr_auto),
`endif
        .y             (y),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .fill_mask     (fill_mask),
        .err_range     (err_range),
        .err_overwrite (err_overwrite),
        .err_clr       (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_sel   = '0;
        y_ready  = 1'b0;
        err_clr  = 1'b0;
        #12;
        chk("rst_y", 64'(y), 64'h0);
        chk("rst_yv", 64'(y_valid), 64'h0);
        chk("rst_mask", 64'(fill_mask), 64'h0);
        chk("rst_erng", 64'(err_range), 64'h0);
        chk("rst_eovw", 64'(err_overwrite), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_wrdy", 64'(wr_ready), 64'h1);
        step();

        // Fill slots 0..11 with sel+1
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(i);
            wr_data  = 4'(i + 1);
            step();
            if (i == 10) chk("fill_yv_early", 64'(y_valid), 64'h0);
        end
        wr_valid = 1'b0;
        chk("fill_yv", 64'(y_valid), 64'h1);
        chk("fill_y", 64'(y), 64'hCBA987654321);
        chk("fill_mask", 64'(fill_mask), 64'hFFF);
        chk("fill_wrdy", 64'(wr_ready), 64'h0);

        // Backpressure: an offered write must not be taken
        wr_valid = 1'b1;
        wr_sel   = 4'd0;
        wr_data  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_y", 64'(y), 64'hCBA987654321);
            chk("bp_wrdy", 64'(wr_ready), 64'h0);
        end
        chk("bp_mask", 64'(fill_mask), 64'hFFF);

        // Handoff with a simultaneous write
        y_ready = 1'b1;
        wr_sel  = 4'd3;
        wr_data = 4'h7;
        #1;
        chk("ho_wrdy", 64'(wr_ready), 64'h1);
        step();
        y_ready  = 1'b0;
        wr_valid = 1'b0;
        chk("ho_yv", 64'(y_valid), 64'h0);
        chk("ho_y", 64'(y), 64'h000000007000);
        chk("ho_mask", 64'(fill_mask), 64'h008);

        // Out-of-range writes
        wr_valid = 1'b1;
        wr_sel   = 4'd13;
        wr_data  = 4'hF;
        step();
        wr_valid = 1'b0;
        chk("rng_y", 64'(y), 64'h000000007000);
        chk("rng_mask", 64'(fill_mask), 64'h008);
        chk("rng_err", 64'(err_range), 64'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("rng_clr", 64'(err_range), 64'h0);
        wr_valid = 1'b1;
        wr_sel   = 4'd12;
        err_clr  = 1'b1;
        step();
        err_clr = 1'b0;
        chk("rng_clr_prio", 64'(err_range), 64'h0);
        step();
        wr_valid = 1'b0;
        chk("rng_sel12", 64'(err_range), 64'h1);
        chk("rng_sel12_mask", 64'(fill_mask), 64'h008);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Overwrite of slot 2
        wr_valid = 1'b1;
        wr_sel   = 4'd2;
        wr_data  = 4'h5;
        step();
        chk("ovw_first", 64'(err_overwrite), 64'h0);
        wr_data = 4'hA;
        step();
        wr_valid = 1'b0;
        chk("ovw_slot", 64'(y[11:8]), 64'hA);
        chk("ovw_y", 64'(y), 64'h000000007A00);
        chk("ovw_mask", 64'(fill_mask), 64'h00C);
        chk("ovw_err", 64'(err_overwrite), 64'h1);
        chk("ovw_erng", 64'(err_range), 64'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovw_clr", 64'(err_overwrite), 64'h0);

        // Reset in the middle of a frame (six slots filled)
        for (int i = 4; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(i);
            wr_data  = 4'h1;
            step();
        end
        wr_valid = 1'b0;
        chk("mid_mask", 64'(fill_mask), 64'h0FC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", 64'(y), 64'h0);
        chk("arst_mask", 64'(fill_mask), 64'h0);
        chk("arst_yv", 64'(y_valid), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(i);
            wr_data  = 4'h5;
            step();
            if (i == 10) chk("refill_yv_early", 64'(y_valid), 64'h0);
        end
        wr_valid = 1'b0;
        chk("refill_yv", 64'(y_valid), 64'h1);
        chk("refill_y", 64'(y), 64'h555555555555);

        // Plain handoff with no write
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        chk("ho2_yv", 64'(y_valid), 64'h0);
        chk("ho2_y", 64'(y), 64'h0);
        chk("ho2_mask", 64'(fill_mask), 64'h0);

`ifdef DEMUX_FRAME_AUTO_INC_EN
        wr_auto = 1'b1;
        wr_sel  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_data  = 4'(i + 1);
            step();
        end
        wr_valid = 1'b0;
        chk("auto_y", 64'(y), 64'hCBA987654321);
        chk("auto_yv", 64'(y_valid), 64'h1);
        y_ready = 1'b1;
        step();
        y_ready  = 1'b0;
        wr_valid = 1'b1;
        wr_sel   = 4'd9;
        wr_data  = 4'h6;
        step();
        wr_valid = 1'b0;
        wr_auto  = 1'b0;
        chk("auto_wrap", 64'(fill_mask), 64'h001);
        chk("auto_wrap_y", 64'(y), 64'h000000000006);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_frame_assembler.md
Name: demux_frame_assembler

Overview:
Sequential inverse of the N-to-1 word mux: accepts M-bit words, each tagged with a slot select, and writes them into an N*M-bit frame register. Once every slot holds a word, the block presents the full frame downstream with a valid/ready handshake. It sits at the write end of the multi-word datapath and feeds the mux trees that read the packed bus. Defaults are 12 slots of 4 bits.

Parameters:
N, 12, number of slots in the frame
M, 4, word width in bits
S, 4, select width; must satisfy 2^S >= N

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write word offered
wr_ready  output  1  write can be accepted this cycle
wr_data  input  M  word to store
wr_sel  input  S  destination slot index
y  output  N*M  assembled frame; slot k at y[k*M +: M]
y_valid  output  1  frame complete and held
y_ready  input  1  downstream accepts frame
fill_mask  output  N  bit k set = slot k written in current frame
err_range  output  1  sticky; a write used wr_sel >= N
err_overwrite  output  1  sticky; a write hit an already-filled slot
err_clr  input  1  synchronous clear of both error flags

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_valid=0, fill_mask=0, err_range=0, err_overwrite=0, state FILL. wr_ready reads 1 as soon as reset is released.
- States:
  - FILL (y_valid=0).
  - FULL (y_valid=1).
- wr_ready = !y_valid || y_ready. This is combinational from y_ready and allows a write in the same cycle as the frame handoff.
- Write accept: wr_valid && wr_ready at edge t. The slot in y and the fill_mask bit update at t+1 (1-cycle latency).
- FILL -> FULL: when the write at t sets the last clear mask bit, y_valid=1 at t+1.
- FULL hold: y and fill_mask stay frozen while y_valid && !y_ready. No writes are accepted in this condition.
- FULL -> FILL on y_valid && y_ready at t:
  - At t+1: y=0, fill_mask=0, y_valid=0.
  - Exception: if a write is accepted in the same cycle, that slot holds wr_data and its mask bit is set at t+1.
- Out-of-range write (wr_sel >= N):
  - The handshake completes; nothing is stored.
  - err_range=1 at t+1; mask unchanged.
- Overwrite (slot already filled in FILL): y slot takes the new wr_data, mask unchanged, err_overwrite=1 at t+1.
- Error flags are sticky until err_clr or reset.
  - err_clr has priority over a set in the same cycle, so flags read 0 at t+1.
- Reset mid-fill discards partial frame and mask immediately, without waiting for a clock edge.
- N=1: the first accepted write makes the frame full.

Optional Feature:
- Macro: DEMUX_FRAME_AUTO_INC_EN.
- When defined:
  - Adds input wr_auto (1 bit) and an internal ceil(log2 N)-bit slot pointer, reset to 0.
  - A write with wr_auto=1 ignores wr_sel and stores to slot = pointer. The pointer advances by 1 and wraps N-1 -> 0.
  - The pointer resets to 0 on every frame handoff.
  - A write with wr_auto=0 behaves as above and leaves the pointer unchanged.
- When undefined: no wr_auto port, no pointer; all writes use wr_sel.

Test Plan:
- Fill: sel 0..11, data=sel+1, one write per cycle, y_ready=0 -> y_valid=1 the cycle after write 12, y=48'hCBA987654321, fill_mask=12'hFFF, wr_ready=0.
- Backpressure then handoff: continue the case above, hold y_ready=0 for 5 cycles -> y stable and wr_ready=0. Then y_ready=1 with wr_valid=1, sel=3, data=4'h7 -> next cycle y_valid=0, y=48'h000000007000, fill_mask=12'h008.
- Range error: wr_sel=13, data=4'hF in FILL -> y and mask unchanged, err_range=1 next cycle. err_clr=1 for one cycle -> err_range=0.
- Overwrite: write sel 2 data 4'h5, then sel 2 data 4'hA -> y[11:8]=4'hA, fill_mask=12'h004, err_overwrite=1.
- Reset mid-frame: 6 slots written, pulse rst_n low between edges -> y=0, fill_mask=0, y_valid=0 immediately. After release, 12 fresh writes are needed to complete a frame.
- With DEMUX_FRAME_AUTO_INC_EN: 12 writes with wr_auto=1, data 1..12, wr_sel=0 -> y=48'hCBA987654321. After handoff the next auto write lands in slot 0.
